// File: rtl/road_scroller.sv
// rtl/road_scroller.sv - multi-layer parallax scroll-position generator
// Each layer steps its offset once per (speed+1) enabled ticks; a scene change resyncs all layers.
module road_scroller #(
  parameter int POS_W  = 5,
  parameter int SPD_W  = 8,
  parameter int LAYERS = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clk_en,
  input  logic [1:0]              scene,
  input  logic                    pause,
  input  logic [LAYERS*SPD_W-1:0] speed,
  input  logic [LAYERS-1:0]       dir,
  output logic [LAYERS*POS_W-1:0] pos,
  output logic [LAYERS-1:0]       wrap,
  output logic                    resync
);

  typedef enum logic [1:0] {RUN, HOLD, RESYNC} state_t;

  state_t           state;
  logic [1:0]       scene_q;
  logic [SPD_W-1:0] k [LAYERS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= RUN;
      scene_q <= 2'b00;
      pos     <= '0;
      wrap    <= '0;
      resync  <= 1'b0;
      for (int i = 0; i < LAYERS; i++) k[i] <= '0;
    end else begin
      wrap   <= '0;
      resync <= 1'b0;
      // A scene change outranks pause and clk_en, whatever state we are in.
      if (scene != scene_q) begin
        state   <= RESYNC;
        scene_q <= scene;
        pos     <= '0;
        resync  <= 1'b1;
        for (int i = 0; i < LAYERS; i++) k[i] <= '0;
      end else begin
        case (state)
          RUN: begin
            if (pause) begin
              state <= HOLD;
            end else if (clk_en) begin
              for (int i = 0; i < LAYERS; i++) begin
                // >= lets a speed lowered below the running count step immediately.
                if (k[i] >= speed[i*SPD_W +: SPD_W]) begin
                  k[i] <= '0;
                  if (dir[i]) begin
                    pos[i*POS_W +: POS_W] <= pos[i*POS_W +: POS_W] - 1'b1;
                    wrap[i] <= (pos[i*POS_W +: POS_W] == '0);
                  end else begin
                    pos[i*POS_W +: POS_W] <= pos[i*POS_W +: POS_W] + 1'b1;
                    wrap[i] <= (pos[i*POS_W +: POS_W] == {POS_W{1'b1}});
                  end
                end else begin
                  k[i] <= k[i] + 1'b1;
                end
              end
            end
          end
          HOLD: begin
            if (!pause) state <= RUN;
          end
          default: begin
            state <= pause ? HOLD : RUN;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_road_scroller.sv
// tb/tb_road_scroller.sv - directed self-checking bench for road_scroller
module tb_road_scroller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clk_en;
  logic [1:0]  scene;
  logic        pause;
  logic [15:0] speed;
  logic [1:0]  dir;
  logic [9:0]  pos;
  logic [1:0]  wrap;
  logic        resync;

  int tests = 0;
  int fails = 0;

  road_scroller #(.POS_W(5), .SPD_W(8), .LAYERS(2)) dut (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .scene(scene), .pause(pause),
    .speed(speed), .dir(dir), .pos(pos), .wrap(wrap), .resync(resync)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; scene = 2'b00; pause = 1'b0; clk_en = 1'b0; dir = 2'b00; speed = 16'd0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; scene = 2'b00; pause = 1'b0; clk_en = 1'b1; dir = 2'b00; speed = 16'd0;
    tick(3);
    tests++; if (pos !== 10'd0) begin fails++; $display("FAIL reset_pos got %0h exp 0", pos); end
    tests++; if (wrap !== 2'b00) begin fails++; $display("FAIL reset_wrap got %b exp 00", wrap); end
    tests++; if (resync !== 1'b0) begin fails++; $display("FAIL reset_resync got %b exp 0", resync); end
    do_reset();
  endtask

  task automatic test_basic_step();
    do_reset();
    speed = {8'd0, 8'd3}; dir = 2'b00; clk_en = 1'b1;
    tick(8);
    tests++; if (pos[4:0] !== 5'd2) begin fails++; $display("FAIL t1_pos0 got %0d exp 2", pos[4:0]); end
    tests++; if (pos[9:5] !== 5'd8) begin fails++; $display("FAIL t1_pos1 got %0d exp 8", pos[9:5]); end
    clk_en = 1'b0;
    tick(3);
    tests++; if (pos !== {5'd8, 5'd2}) begin fails++; $display("FAIL t1_hold_no_en got %0h exp %0h", pos, {5'd8, 5'd2}); end
  endtask

  task automatic test_layers_dir();
    do_reset();
    speed = {8'd2, 8'd1}; dir = 2'b10; clk_en = 1'b1;
    tick(3);
    tests++; if (pos[9:5] !== 5'd31) begin fails++; $display("FAIL lay_pos1_down got %0d exp 31", pos[9:5]); end
    tests++; if (wrap !== 2'b10) begin fails++; $display("FAIL lay_wrap1 got %b exp 10", wrap); end
    tick(3);
    tests++; if (pos[4:0] !== 5'd3) begin fails++; $display("FAIL lay_pos0 got %0d exp 3", pos[4:0]); end
    tests++; if (pos[9:5] !== 5'd30) begin fails++; $display("FAIL lay_pos1 got %0d exp 30", pos[9:5]); end
  endtask

  task automatic test_wrap();
    do_reset();
    speed = {8'd255, 8'd0}; dir = 2'b00; clk_en = 1'b1;
    tick(31);
    tests++; if (pos[4:0] !== 5'd31 || wrap !== 2'b00) begin fails++; $display("FAIL t2_pre got pos0=%0d wrap=%b exp 31/00", pos[4:0], wrap); end
    tick(1);
    tests++; if (pos[4:0] !== 5'd0) begin fails++; $display("FAIL t2_up_pos got %0d exp 0", pos[4:0]); end
    tests++; if (wrap !== 2'b01) begin fails++; $display("FAIL t2_up_wrap got %b exp 01", wrap); end
    clk_en = 1'b0;
    tick(1);
    tests++; if (wrap !== 2'b00) begin fails++; $display("FAIL t2_wrap_one_cycle got %b exp 00", wrap); end
    dir = 2'b01; clk_en = 1'b1;
    tick(1);
    tests++; if (pos[4:0] !== 5'd31) begin fails++; $display("FAIL t2_down_pos got %0d exp 31", pos[4:0]); end
    tests++; if (wrap !== 2'b01) begin fails++; $display("FAIL t2_down_wrap got %b exp 01", wrap); end
    tests++; if (pos[9:5] !== 5'd0) begin fails++; $display("FAIL t2_pos1_idle got %0d exp 0", pos[9:5]); end
  endtask

  task automatic test_pause();
    do_reset();
    speed = {8'd255, 8'd5}; dir = 2'b00; clk_en = 1'b1;
    tick(2);
    pause = 1'b1;
    tick(10);
    tests++; if (pos !== 10'd0) begin fails++; $display("FAIL t3_paused got %0h exp 0", pos); end
    pause = 1'b0;
    tick(4);
    tests++; if (pos[4:0] !== 5'd0) begin fails++; $display("FAIL t3_early got %0d exp 0", pos[4:0]); end
    tick(1);
    tests++; if (pos[4:0] !== 5'd1) begin fails++; $display("FAIL t3_resume got %0d exp 1", pos[4:0]); end
  endtask

  task automatic test_resync();
    do_reset();
    speed = {8'd255, 8'd0}; dir = 2'b00; clk_en = 1'b1;
    tick(17);
    tests++; if (pos[4:0] !== 5'd17) begin fails++; $display("FAIL t4_pre got %0d exp 17", pos[4:0]); end
    pause = 1'b1;
    tick(1);
    scene = 2'd2;
    tick(1);
    tests++; if (pos !== 10'd0) begin fails++; $display("FAIL t4_pos_clear got %0h exp 0", pos); end
    tests++; if (resync !== 1'b1) begin fails++; $display("FAIL t4_resync got %b exp 1", resync); end
    tick(1);
    tests++; if (resync !== 1'b0) begin fails++; $display("FAIL t4_resync_one got %b exp 0", resync); end
    tick(2);
    tests++; if (pos[4:0] !== 5'd0) begin fails++; $display("FAIL t4_hold got %0d exp 0", pos[4:0]); end
    pause = 1'b0;
    tick(2);
    tests++; if (pos[4:0] !== 5'd1) begin fails++; $display("FAIL t4_resume got %0d exp 1", pos[4:0]); end
  endtask

  task automatic test_speed_drop();
    do_reset();
    speed = {8'd255, 8'd10}; dir = 2'b00; clk_en = 1'b1;
    tick(6);
    speed = {8'd255, 8'd4};
    tick(1);
    tests++; if (pos[4:0] !== 5'd1) begin fails++; $display("FAIL t5_immediate got %0d exp 1", pos[4:0]); end
    tick(4);
    tests++; if (pos[4:0] !== 5'd1) begin fails++; $display("FAIL t5_k_cleared got %0d exp 1", pos[4:0]); end
    tick(1);
    tests++; if (pos[4:0] !== 5'd2) begin fails++; $display("FAIL t5_next got %0d exp 2", pos[4:0]); end
  endtask

  task automatic test_async_reset();
    do_reset();
    speed = {8'd2, 8'd0}; dir = 2'b00; clk_en = 1'b1;
    tick(32);
    tests++; if (wrap !== 2'b01 || pos[9:5] !== 5'd10) begin fails++; $display("FAIL t6_pre got wrap=%b pos1=%0d exp 01/10", wrap, pos[9:5]); end
    #2 rst_n = 1'b0;
    #1;
    tests++; if (pos !== 10'd0 || wrap !== 2'b00) begin fails++; $display("FAIL t6_async got pos=%0h wrap=%b exp 0/00", pos, wrap); end
    do_reset();
    scene = 2'd1;
    tick(1);
    tests++; if (resync !== 1'b1) begin fails++; $display("FAIL t6_resync_pre got %b exp 1", resync); end
    #2 rst_n = 1'b0;
    #1;
    tests++; if (resync !== 1'b0) begin fails++; $display("FAIL t6_resync_async got %b exp 0", resync); end
    do_reset();
  endtask

  initial begin
    test_reset();
    test_basic_step();
    test_layers_dir();
    test_wrap();
    test_pause();
    test_resync();
    test_speed_drop();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
